// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame arbiter.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [39:0] DEFAULT_FRAME = 40'h55_5A_02_D3_84;
  localparam logic [7:0]  HDR0          = 8'h55;
  localparam logic [7:0]  HDR1          = 8'h5A;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr wins.
module uart_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner
);

  int   idx;
  logic found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_frame_arb.sv
// Shares one UART TX among NREQ frame sources: round-robin grant, MSB-byte-first
// streaming, optional additive checksum byte and an inter-frame gap.
//
// state | meaning
// IDLE  | waiting for any request; grants and latches a frame
// SEND  | presenting bytes on o_data/o_valid until the last one is accepted
// GAP   | enforced idle time after a frame
module uart_frame_arb
  import uart_frame_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int FRAME_BYTES = 5,
  parameter int CHECKSUM    = 1,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NREQ-1:0]               i_req,
  input  logic [NREQ*FRAME_BYTES*8-1:0] i_frame,
  output logic [NREQ-1:0]               o_grant,
  output logic [NREQ-1:0]               o_done,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_busy
);

  localparam int FW    = FRAME_BYTES * 8;
  localparam int TOTAL = FRAME_BYTES + ((CHECKSUM != 0) ? 1 : 0);
  localparam int CW    = $clog2(FRAME_BYTES + 2);
  localparam int GW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state, state_n;
  logic [FW-1:0]   shreg, shreg_n, shifted, win_frame;
  logic [CW-1:0]   cnt, cnt_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;
  logic [7:0]      acc, acc_n, data_n;
  logic [PW-1:0]   ptr, ptr_n, owner, owner_n, winner;
  logic [NREQ-1:0] pick_grant, grant_n, done_n;
  logic            valid_n, busy_n;

  uart_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (i_req),
    .ptr    (ptr),
    .grant  (pick_grant),
    .winner (winner)
  );

  assign win_frame = i_frame[int'(winner)*FW +: FW];
  assign shifted   = shreg << 8;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      acc     <= '0;
      ptr     <= '0;
      owner   <= '0;
      o_grant <= '0;
      o_done  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      cnt     <= cnt_n;
      gap_cnt <= gap_cnt_n;
      acc     <= acc_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      o_grant <= grant_n;
      o_done  <= done_n;
      o_data  <= data_n;
      o_valid <= valid_n;
      o_busy  <= busy_n;
    end
  end

  // All outputs are registered from their *_n values, so i_req/i_ready never reach a port combinationally.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = cnt;
    gap_cnt_n = gap_cnt;
    acc_n     = acc;
    ptr_n     = ptr;
    owner_n   = owner;
    grant_n   = '0;
    done_n    = '0;
    data_n    = o_data;
    valid_n   = o_valid;
    unique case (state)
      IDLE: begin
        if (|i_req) begin
          state_n = SEND;
          shreg_n = win_frame;
          data_n  = win_frame[FW-1 -: 8];
          cnt_n   = CW'(TOTAL);
          acc_n   = '0;
          grant_n = pick_grant;
          owner_n = winner;
          ptr_n   = (int'(winner) == NREQ - 1) ? '0 : winner + PW'(1);
          valid_n = 1'b1;
        end
      end
      SEND: begin
        if (o_valid && i_ready) begin
          acc_n   = acc + o_data;
          shreg_n = shifted;
          cnt_n   = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            valid_n = 1'b0;
            data_n  = '0;
            done_n  = NREQ'(1) << owner;
            if (GAP_CYCLES == 0) begin
              state_n = IDLE;
            end else begin
              state_n   = GAP;
              gap_cnt_n = GW'(GAP_CYCLES);
            end
          end else if (CHECKSUM != 0 && cnt == CW'(2)) begin
            // the accumulator already holds every payload byte but the one leaving now
            data_n = acc + o_data;
          end else begin
            data_n = shifted[FW-1 -: 8];
          end
        end
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) begin
          state_n   = IDLE;
          gap_cnt_n = '0;
        end else begin
          gap_cnt_n = gap_cnt - GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_frame_arb.sv
// Scoreboard bench: stimulus pushes expected grant/byte/done events, a negedge monitor pops and compares.
module tb_uart_frame_arb;
  import uart_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_a, req_b, grant_a, grant_b, done_a, done_b;
  logic [79:0] frame_a, frame_b;
  logic [7:0]  data_a, data_b;
  logic        valid_a, valid_b, ready_a, ready_b, busy_a, busy_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // event encoding: {kind, value}; kind 0 = grant, 1 = byte, 2 = done
  logic [9:0] exp_a[$], exp_b[$];
  int gcyc_a[$], dcyc_a[$], gcyc_b[$], dcyc_b[$];

  uart_frame_arb #(.NREQ(2), .FRAME_BYTES(5), .CHECKSUM(1), .GAP_CYCLES(4)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_req(req_a), .i_frame(frame_a), .o_grant(grant_a),
    .o_done(done_a), .o_data(data_a), .o_valid(valid_a), .i_ready(ready_a), .o_busy(busy_a));

  uart_frame_arb #(.NREQ(2), .FRAME_BYTES(5), .CHECKSUM(0), .GAP_CYCLES(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_req(req_b), .i_frame(frame_b), .o_grant(grant_b),
    .o_done(done_b), .o_data(data_b), .o_valid(valid_b), .i_ready(ready_b), .o_busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int d, input logic [9:0] ev);
    logic [9:0] e;
    int sz;
    sz = (d == 0) ? exp_a.size() : exp_b.size();
    checks++;
    if (sz == 0) begin
      failures++;
      $display("FAIL event_%0d unexpected actual=%h required=none cycle=%0d", d, ev, cyc);
    end else begin
      if (d == 0) e = exp_a.pop_front();
      else        e = exp_b.pop_front();
      if (ev !== e) begin
        failures++;
        $display("FAIL event_%0d actual=%h required=%h cycle=%0d", d, ev, e, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (grant_a != 2'b00) begin
        gcyc_a.push_back(cyc);
        observe(0, {2'd0, 6'd0, grant_a});
        check("grant_a_valid", valid_a, 1);
      end
      if (valid_a && ready_a) observe(0, {2'd1, data_a});
      if (done_a != 2'b00) begin
        dcyc_a.push_back(cyc);
        observe(0, {2'd2, 6'd0, done_a});
        check("done_a_valid_low", valid_a, 0);
      end
      if (grant_b != 2'b00) begin
        gcyc_b.push_back(cyc);
        observe(1, {2'd0, 6'd0, grant_b});
      end
      if (valid_b && ready_b) observe(1, {2'd1, data_b});
      if (done_b != 2'b00) begin
        dcyc_b.push_back(cyc);
        observe(1, {2'd2, 6'd0, done_b});
      end
    end
  end

  task automatic push_ev(input int d, input logic [9:0] ev);
    if (d == 0) exp_a.push_back(ev);
    else        exp_b.push_back(ev);
  endtask

  task automatic push_frame(input int d, input logic [1:0] g, input logic [39:0] fr, input bit cs,
                            input logic [7:0] sum);
    logic [39:0] f;
    f = fr;
    push_ev(d, {2'd0, 6'd0, g});
    for (int i = 0; i < 5; i++) begin
      push_ev(d, {2'd1, f[39:32]});
      f = f << 8;
    end
    if (cs) push_ev(d, {2'd1, sum});
    push_ev(d, {2'd2, 6'd0, g});
  endtask

  function automatic int count(input int d, input int kind);
    if (d == 0) return (kind == 0) ? gcyc_a.size() : dcyc_a.size();
    return (kind == 0) ? gcyc_b.size() : dcyc_b.size();
  endfunction

  task automatic wait_count(input int d, input int kind, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (count(d, kind) < n && k < budget) begin
      @(posedge clk); #2; k++;
    end
    checks++;
    if (count(d, kind) < n) begin
      failures++;
      $display("FAIL %s timeout actual=%0d required=%0d", name, count(d, kind), n);
    end
  endtask

  task automatic wait_idle_a(input string name);
    int k;
    k = 0;
    while (busy_a && k < 50) begin
      @(posedge clk); #2; k++;
    end
    check(name, busy_a, 0);
  endtask

  int g, d, creq;

  initial begin
    rst = 1'b1; req_a = '0; req_b = '0; ready_a = 1'b1; ready_b = 1'b1;
    frame_a = {40'h11_22_33_44_F0, DEFAULT_FRAME};
    frame_b = {40'h01_02_03_04_05, 40'hFF_FF_FF_FF_FF};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_grant", grant_a, 0);
    check("rst_done", done_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_b_all", {valid_b, busy_b, grant_b, done_b, data_b}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single frame, checksum 08, gap 4
    @(posedge clk); #1;
    push_frame(0, 2'b01, DEFAULT_FRAME, 1, 8'h08);
    req_a = 2'b01; creq = cyc;
    wait_count(0, 0, 1, 20, "t1_grant");
    req_a = '0;
    g = gcyc_a[0];
    check("t1_req_to_grant", g - creq, 1);
    wait_count(0, 1, 1, 50, "t1_done");
    d = dcyc_a[0];
    check("t1_frame_cycles", d - g, 6);
    wait_idle_a("t1_busy_low");
    check("t1_busy_low_delay", cyc - d, 4);

    // both requesting: alternate 01,10,01,10 from ptr 0
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    gcyc_a.delete(); dcyc_a.delete();
    push_frame(0, 2'b01, DEFAULT_FRAME, 1, 8'h08);
    push_frame(0, 2'b10, 40'h11_22_33_44_F0, 1, 8'h9A);
    push_frame(0, 2'b01, DEFAULT_FRAME, 1, 8'h08);
    push_frame(0, 2'b10, 40'h11_22_33_44_F0, 1, 8'h9A);
    req_a = 2'b11;
    wait_count(0, 0, 4, 200, "t2_grants");
    req_a = '0;
    wait_count(0, 1, 4, 100, "t2_dones");
    for (int i = 0; i < 4; i++) check("t2_frame_cycles", dcyc_a[i] - gcyc_a[i], 6);
    for (int i = 1; i < 4; i++) check("t2_gap", gcyc_a[i] - dcyc_a[i-1], 5);
    wait_idle_a("t2_idle");

    // stall on D3: ready 1 then 0,0 then 1
    gcyc_a.delete(); dcyc_a.delete();
    @(posedge clk); #1;
    push_frame(0, 2'b01, DEFAULT_FRAME, 1, 8'h08);
    req_a = 2'b01;
    wait_count(0, 0, 1, 20, "t3_grant");
    req_a = '0;
    g = gcyc_a[0];
    while (cyc < g + 3) begin @(posedge clk); #1; end
    ready_a = 1'b0;
    @(negedge clk);
    check("t3_stall_data0", {valid_a, data_a}, {1'b1, 8'hD3});
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_stall_data1", {valid_a, data_a}, {1'b1, 8'hD3});
    @(posedge clk); #1 ready_a = 1'b1;
    wait_count(0, 1, 1, 50, "t3_done");
    check("t3_frame_cycles", dcyc_a[0] - g, 8);
    wait_idle_a("t3_idle");

    // reset after two bytes accepted
    gcyc_a.delete(); dcyc_a.delete();
    @(posedge clk); #1;
    push_frame(0, 2'b01, DEFAULT_FRAME, 1, 8'h08);
    req_a = 2'b01;
    wait_count(0, 0, 1, 20, "t4_grant");
    req_a = '0;
    g = gcyc_a[0];
    while (cyc < g + 2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    check("t4_left_in_queue", exp_a.size(), 5);
    exp_a.delete();
    #1;
    check("t4_async_valid", valid_a, 0);
    check("t4_async_busy", busy_a, 0);
    req_a = 2'b11;
    @(posedge clk); #1;
    gcyc_a.delete(); dcyc_a.delete();
    push_frame(0, 2'b01, DEFAULT_FRAME, 1, 8'h08);
    @(posedge clk); #1 rst = 1'b0;
    wait_count(0, 0, 1, 20, "t4_regrant");
    req_a = '0;
    wait_count(0, 1, 1, 50, "t4_done");
    check("t4_frame_cycles", dcyc_a[0] - gcyc_a[0], 6);
    wait_idle_a("t4_idle");

    // no checksum, no gap, back-to-back from requester 0
    @(posedge clk); #1;
    push_frame(1, 2'b01, 40'hFF_FF_FF_FF_FF, 0, 8'h00);
    push_frame(1, 2'b01, 40'hFF_FF_FF_FF_FF, 0, 8'h00);
    req_b = 2'b01;
    wait_count(1, 0, 2, 50, "t5_grants");
    req_b = '0;
    wait_count(1, 1, 2, 50, "t5_dones");
    check("t5_frame0_cycles", dcyc_b[0] - gcyc_b[0], 5);
    check("t5_frame1_cycles", dcyc_b[1] - gcyc_b[1], 5);
    check("t5_done_to_grant", gcyc_b[1] - dcyc_b[0], 1);

    repeat (5) @(posedge clk);
    #2;
    check("end_queue_a", exp_a.size(), 0);
    check("end_queue_b", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
